pipe_skid_stage: RTL and testbench

//  Two-entry skid-buffered pipeline stage with valid/ready handshake, stall and flush.

---
 rtl/pipe_skid_stage.sv | 98 +++++++++
 tb/tb_pipe_skid_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid-buffered valid/ready stage with flush; all outputs from flops.
// Revision 1.0
`default_nettype none

module pipe_skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       count_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Data registers only load on an accepted beat, so X on in_data is harmless while idle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      count_q     <= (state_d == FULL) ? 2'd2 : ((state_d == ONE) ? 2'd1 : 2'd0);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and randomised self-checking bench for pipe_skid_stage.
// Revision 1.0
`default_nettype none

module tb_pipe_skid_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  pipe_skid_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic ov, input logic ir, input logic [1:0] cnt);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    check({tag, ".count"},     {30'd0, count},     {30'd0, cnt});
  endtask

  logic [31:0] sb[$];
  logic        ir_before;
  logic        in_x, out_x;
  logic        prev_stall;
  logic [31:0] prev_data;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b0;
    #12;
    expect_state("reset", 1'b0, 1'b1, 2'd0);
    check("reset.out_data", out_data, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    expect_state("idle_x_data", 1'b0, 1'b1, 2'd0);

    // Pass-through stream with 1-cycle latency and no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h11 + i;
      tick();
      expect_state("t2", 1'b1, 1'b1, 2'd1);
      check("t2.out_data", out_data, 32'h11 + i);
    end
    in_valid = 1'b0;
    in_data  = 'x;
    tick();
    expect_state("t2.drain", 1'b0, 1'b1, 2'd0);

    // Stall fills the skid register
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA0;
    tick();
    expect_state("t3.one", 1'b1, 1'b1, 2'd1);
    in_data = 32'hA1;
    tick();
    expect_state("t3.full", 1'b1, 1'b0, 2'd2);
    check("t3.hold0", out_data, 32'hA0);
    in_data = 32'hEE;
    tick();
    expect_state("t3.full2", 1'b1, 1'b0, 2'd2);
    check("t3.hold1", out_data, 32'hA0);
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b1;
    tick();
    expect_state("t3.pop0", 1'b1, 1'b1, 2'd1);
    check("t3.out1", out_data, 32'hA1);
    tick();
    expect_state("t3.pop1", 1'b0, 1'b1, 2'd0);

    // Simultaneous accept and release while ONE
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB0;
    tick();
    check("t4.out0", out_data, 32'hB0);
    in_data   = 32'hB1;
    out_ready = 1'b1;
    tick();
    expect_state("t4.swap", 1'b1, 1'b1, 2'd1);
    check("t4.out1", out_data, 32'hB1);
    in_valid = 1'b0;
    tick();
    expect_state("t4.drain", 1'b0, 1'b1, 2'd0);

    // Flush from FULL with a pending beat on the input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hC0;
    tick();
    in_data = 32'hC1;
    tick();
    expect_state("t5.full", 1'b1, 1'b0, 2'd2);
    in_data = 32'hCC;
    flush   = 1'b1;
    tick();
    expect_state("t5.flushed", 1'b0, 1'b1, 2'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_state("t5.stays_empty", 1'b0, 1'b1, 2'd0);

    // Flush in ONE drops the same-cycle input beat
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD0;
    tick();
    in_data = 32'hD1;
    flush   = 1'b1;
    tick();
    expect_state("t5.flush_one", 1'b0, 1'b1, 2'd0);
    flush     = 1'b0;
    in_data   = 32'hD2;
    out_ready = 1'b1;
    tick();
    check("t5.after_flush", out_data, 32'hD2);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset in the middle of a cycle while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hE0;
    tick();
    in_data = 32'hE1;
    tick();
    expect_state("t1.full", 1'b1, 1'b0, 2'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_state("t1.async", 1'b0, 1'b1, 2'd0);
    check("t1.out_data", out_data, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic against a queue scoreboard
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ir_before = in_ready;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      check("t6.ready_indep", {31'd0, in_ready}, {31'd0, ir_before});
      check("t6.count", {30'd0, count}, 32'(sb.size()));
      check("t6.valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      if (prev_stall) check("t6.stable", out_data, prev_data);
      in_x = in_valid & in_ready;
      out_x = out_valid & out_ready;
      if (out_valid && sb.size() != 0) check("t6.order", out_data, sb[0]);
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      if (out_x && sb.size() != 0) void'(sb.pop_front());
      if (in_x) sb.push_back(in_data);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
